mult_hilo_unit: RTL and testbench



---
 rtl/mult_hilo_unit.sv | 108 ++++++++++
 tb/tb_mult_hilo_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_hilo_unit.sv
// mult_hilo_unit: iterative 32x32 shift-add multiplier that owns the MIPS
// HI/LO registers. It runs MULT/MULTU over 32 RUN cycles plus one FIX cycle,
// and accepts MTHI/MTLO writes only while idle.
module mult_hilo_unit #(
  parameter int ITER_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = $clog2(ITER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      mcand;
  logic [31:0]      mplier;
  logic [63:0]      acc;
  logic             sign;
  logic [32:0]      sum;
  logic [63:0]      result;

  // Operand magnitude. Negating 0x80000000 wraps to itself, which read as
  // unsigned is exactly 2^31, so no extra bit is needed.
  function automatic logic [31:0] magnitude(input logic signed [31:0] v,
                                            input logic             s);
    logic signed [31:0] neg;
    neg = -v;
    return (s && v[31]) ? neg : v;
  endfunction

  // Restore the product sign with a full 64-bit two's-complement negation.
  function automatic logic [63:0] apply_sign(input logic signed [63:0] v,
                                             input logic             s);
    logic signed [63:0] neg;
    neg = -v;
    return s ? neg : v;
  endfunction

  // Shift-add step: the 33-bit sum keeps the carry that the right shift
  // moves back into bit 63; the signed result is formed for the FIX write.
  always_comb begin
    sum    = {1'b0, acc[63:32]} + (mplier[0] ? {1'b0, mcand} : 33'd0);
    result = apply_sign(acc, sign);
  end

  // Control FSM, datapath iteration and the architectural HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      sign   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // MTHI/MTLO land now; a same-cycle start overwrites them later.
          if (wr_hi) hi <= wdata;
          if (wr_lo) lo <= wdata;
          if (start) begin
            mcand  <= magnitude(a, is_signed);
            mplier <= magnitude(b, is_signed);
            sign   <= is_signed & (a[31] ^ b[31]);
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= {sum, acc[31:1]};
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) state <= FIX;
        end
        FIX: begin
          hi    <= result[63:32];
          lo    <= result[31:0];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Bench for mult_hilo_unit: directed scenarios with literal expectations plus
// randomized multiplies, all checked every cycle against a countdown model.
module tb_mult_hilo_unit;

  logic        clk = 1'b0;
  logic        reset, start, is_signed, wr_hi, wr_lo;
  logic [31:0] a, b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_chk  = 0;
  int n_fail = 0;
  int dut_dones = 0;
  bit seen_bad  = 1'b0;

  // Reference state: a countdown to the product write, not the RTL's FSM.
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_busy = 1'b0, m_done = 1'b0;
  logic [63:0] m_prod = '0;
  int          m_left = 0;

  mult_hilo_unit dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_prod(input logic s, input logic [31:0] x,
                                           input logic [31:0] y);
    longint sx, sy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    return {32'd0, x} * {32'd0, y};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model, updated from the inputs sampled at each rising edge.
  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_left == 0) begin
        if (wr_hi) m_hi = wdata;
        if (wr_lo) m_lo = wdata;
        if (start) begin
          m_prod = ref_prod(is_signed, a, b);
          m_left = 33;
          m_busy = 1'b1;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_hi   = m_prod[63:32];
          m_lo   = m_prod[31:0];
          m_done = 1'b1;
          m_busy = 1'b0;
        end
      end
    end
  end

  // Compare process: every output, every cycle, on the falling edge.
  initial forever begin
    @(negedge clk);
    chk("busy", 64'(busy), 64'(m_busy));
    chk("done", 64'(done), 64'(m_done));
    chk("hi", 64'(hi), 64'(m_hi));
    chk("lo", 64'(lo), 64'(m_lo));
    if (done === 1'b1) dut_dones++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  // kind: 0 quiet, 1 random input noise, 2 late start pulse, 3 wr_lo during run
  task automatic run_mul(input logic s, input logic [31:0] x, input logic [31:0] y,
                         input int kind, output int cyc, output int bcnt);
    is_signed = s; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc  = 1;
    bcnt = busy ? 1 : 0;
    while (done !== 1'b1 && cyc < 40) begin
      case (kind)
        1: begin
          start = 1'($urandom_range(1)); wr_hi = 1'($urandom_range(1));
          wr_lo = 1'($urandom_range(1)); is_signed = 1'($urandom_range(1));
          a = $urandom; b = $urandom; wdata = $urandom;
        end
        2: begin
          start = (cyc == 4);
          if (cyc == 4) begin a = 32'd2; b = 32'd2; end
          if (cyc == 5) a = 32'd0;
        end
        3: begin
          wr_lo = 1'b1; wdata = 32'h0000DEAD;
        end
        default: ;
      endcase
      @(negedge clk);
      cyc++;
      if (busy) bcnt++;
      if (kind == 3 && lo == 32'h0000DEAD) seen_bad = 1'b1;
    end
    start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    if (done !== 1'b1) chk("done_timeout", 64'(done), 64'd1);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cyc, bcnt, d0;
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    a = '0; b = '0; wdata = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // MULTU max x max; cyc-1 = edges after acceptance until done is seen
    run_mul(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, cyc, bcnt);
    chk("multu_latency", 64'(cyc - 1), 64'd33);
    chk("multu_busy_cycles", 64'(bcnt), 64'd33);
    chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("multu_lo", 64'(lo), 64'h0000_0001);

    run_mul(1'b1, 32'hFFFF_FFFD, 32'd5, 0, cyc, bcnt);
    chk("mult_m3x5_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_m3x5_lo", 64'(lo), 64'hFFFF_FFF1);
    run_mul(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, cyc, bcnt);
    chk("mult_m1xm1_hi", 64'(hi), 64'd0);
    chk("mult_m1xm1_lo", 64'(lo), 64'd1);
    run_mul(1'b1, 32'h8000_0000, 32'h8000_0000, 0, cyc, bcnt);
    chk("mult_min_hi", 64'(hi), 64'h4000_0000);
    chk("mult_min_lo", 64'(lo), 64'd0);

    // start while busy is ignored and operand changes have no effect
    d0 = dut_dones;
    run_mul(1'b0, 32'd7, 32'd6, 2, cyc, bcnt);
    chk("ignore_hi", 64'(hi), 64'd0);
    chk("ignore_lo", 64'(lo), 64'd42);
    repeat (40) @(negedge clk);
    chk("ignore_one_done", 64'(dut_dones - d0), 64'd1);
    chk("ignore_idle", 64'(busy), 64'd0);

    // MTHI in idle
    wr_hi = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    wr_hi = 1'b0;
    chk("mthi_hi", 64'(hi), 64'h1234_5678);
    chk("mthi_lo_kept", 64'(lo), 64'd42);

    // MTLO during run is ignored
    run_mul(1'b0, 32'd5, 32'd5, 3, cyc, bcnt);
    chk("mtlo_run_lo", 64'(lo), 64'd25);
    chk("mtlo_run_hi", 64'(hi), 64'd0);
    chk("mtlo_run_never_visible", 64'(seen_bad), 64'd0);

    // reset mid-operation abandons the multiply
    is_signed = 1'b0; a = 32'd3; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    d0 = dut_dones;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_hi", 64'(hi), 64'd0);
    chk("rst_mid_lo", 64'(lo), 64'd0);
    repeat (40) @(negedge clk);
    chk("rst_mid_no_done", 64'(dut_dones - d0), 64'd0);
    run_mul(1'b0, 32'd3, 32'd3, 0, cyc, bcnt);
    chk("after_rst_lo", 64'(lo), 64'd9);
    chk("after_rst_latency", 64'(cyc - 1), 64'd33);

    // same-cycle start and MTLO
    is_signed = 1'b0; a = 32'd2; b = 32'd3; start = 1'b1; wr_lo = 1'b1; wdata = 32'hAAAA;
    @(negedge clk);
    start = 1'b0; wr_lo = 1'b0;
    chk("simul_lo_now", 64'(lo), 64'hAAAA);
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("simul_done_seen", 64'(done), 64'd1);
    chk("simul_lo", 64'(lo), 64'd6);
    chk("simul_hi", 64'(hi), 64'd0);

    // randomized multiplies with idle MTHI/MTLO and noise while busy
    for (int i = 0; i < 30; i++) begin
      wr_hi = 1'($urandom_range(1)); wr_lo = 1'($urandom_range(1)); wdata = $urandom;
      @(negedge clk);
      wr_hi = 1'b0; wr_lo = 1'b0;
      run_mul(1'($urandom_range(1)), pick_operand(), pick_operand(), 1, cyc, bcnt);
      chk("rand_latency", 64'(cyc - 1), 64'd33);
    end
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
